calc_result_collector: RTL and testbench

Downstream stage of the single calc unit. Samples the FP32 accumulator result once per completed dot product, using a delayed copy of the last-beat strobe. Packs 16 consecutive results into one 512-bit output word and queues words in a small FIFO for the output-buffer writer. The calc pipeline cannot stall, so the block exports an early-warning stall and a sticky overflow flag instead of back-pressuring the accumulator.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/result_fifo.sv | 60 ++++++
 rtl/calc_result_collector.sv | 111 +++++++++++
 tb/tb_calc_result_collector.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calc-unit definitions: FP32 result layout, lane count and a ReLU helper.
package calc_pkg;

    localparam int BITWIDTH = 32;
    localparam int LANES    = 16;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    localparam logic [BITWIDTH-1:0] FP_ZERO = '0;

    // Negative non-NaN values (including -0.0) clamp to +0.0; NaN passes unchanged.
    function automatic logic [BITWIDTH-1:0] fp_relu(input logic [BITWIDTH-1:0] v);
        logic is_nan;
        is_nan = (&v[EXP_MSB:EXP_LSB]) && (|v[MAN_MSB:0]);
        return (v[SIGN_BIT] && !is_nan) ? FP_ZERO : v;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Single-clock shift-register FIFO; entry 0 is the registered head, vacated slots refill with zero.
module result_fifo #(
    parameter  int WIDTH = 528,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] mem_n [DEPTH];
    logic [CW-1:0]    count_n;
    logic [AW-1:0]    wr_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[0];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign wr_idx  = AW'(do_pop ? count - CW'(1) : count);

    always_comb begin
        mem_n = mem;
        if (do_pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                mem_n[i] = mem[i + 1];
            end
            mem_n[DEPTH-1] = '0;
        end
        if (do_push) begin
            mem_n[wr_idx] = push_data;
        end
        count_n = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_n;
            mem   <= mem_n;
        end
    end

endmodule

// File: rtl/calc_result_collector.sv
// Packs FP32 accumulator results into 16-lane words and queues them for the output-buffer writer.
// Optional macro RESULT_RELU_EN clamps negative non-NaN results to +0.0 at capture.
module calc_result_collector
    import calc_pkg::*;
#(
    parameter int BANDWIDTH  = 512,
    parameter int BITWIDTH   = calc_pkg::BITWIDTH,
    parameter int PIPE_LAT   = 18,
    parameter int FIFO_DEPTH = 4
)(
    input  logic                 clk_calc,
    input  logic                 areset,
    input  logic [BITWIDTH-1:0]  acc_data,
    input  logic                 last_in,
    input  logic                 flush,
    output logic [BANDWIDTH-1:0] out_data,
    output logic [15:0]          out_mask,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 pack_stall,
    output logic                 ovf_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(LANES);
    localparam int EW = BANDWIDTH + LANES;

    logic [PIPE_LAT-1:0]  dly;
    logic                 cap;
    logic [BITWIDTH-1:0]  cap_val;
    logic [LW-1:0]        lane_cnt;
    logic [BANDWIDTH-1:0] pack_q;
    logic [BANDWIDTH-1:0] pack_n;
    logic [LANES-1:0]     mask_q;
    logic [LANES-1:0]     mask_n;
    logic                 complete;
    logic                 pop;
    logic [EW-1:0]        head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    always_ff @(posedge clk_calc or posedge areset) begin
        if (areset) begin
            dly <= '0;
        end else begin
            dly <= {dly[PIPE_LAT-2:0], last_in};
        end
    end

    assign cap = dly[PIPE_LAT-1];

`ifdef RESULT_RELU_EN
    assign cap_val = fp_relu(acc_data);
`else
    assign cap_val = acc_data;
`endif

    // pack_n/mask_n include this cycle's capture, so a coincident flush closes a word containing it.
    always_comb begin
        pack_n = pack_q;
        mask_n = mask_q;
        if (cap) begin
            pack_n[lane_cnt*BITWIDTH +: BITWIDTH] = cap_val;
            mask_n[lane_cnt]                      = 1'b1;
        end
        complete = (cap && lane_cnt == LW'(LANES - 1)) || (flush && (cap || lane_cnt != '0));
    end

    always_ff @(posedge clk_calc or posedge areset) begin
        if (areset) begin
            lane_cnt <= '0;
            pack_q   <= '0;
            mask_q   <= '0;
            ovf_err  <= 1'b0;
        end else if (complete) begin
            lane_cnt <= '0;
            pack_q   <= '0;
            mask_q   <= '0;
            if (fifo_full && !pop) begin
                ovf_err <= 1'b1;
            end
        end else if (cap) begin
            lane_cnt <= lane_cnt + LW'(1);
            pack_q   <= pack_n;
            mask_q   <= mask_n;
        end
    end

    result_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_calc),
        .rst      (areset),
        .push     (complete),
        .push_data({mask_n, pack_n}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign pop        = out_vld && out_rdy;
    assign out_vld    = !fifo_empty;
    assign out_data   = head[BANDWIDTH-1:0];
    assign out_mask   = head[EW-1 -: LANES];
    assign pack_stall = (fifo_count >= CW'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_calc_result_collector.sv
// Directed bench for calc_result_collector: vector table of packing cases plus overflow/reset sequences.
module tb_calc_result_collector;

    localparam int PIPE_LAT = 18;

    logic         clk_calc;
    logic         areset;
    logic [31:0]  acc_data;
    logic         last_in;
    logic         flush;
    logic [511:0] out_data;
    logic [15:0]  out_mask;
    logic         out_vld;
    logic         out_rdy;
    logic         pack_stall;
    logic         ovf_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [31:0] acc_sched [int];

    typedef struct packed {
        logic [15:0][31:0] vals;
        logic [15:0][31:0] exp_lanes;
        logic [4:0]        n;
        logic [1:0]        mode;      // 0: word fills itself, 1: flush on last cap, 2: flush cycle after
        logic [15:0]       exp_mask;
    } vec_t;

    vec_t vecs [5];

    calc_result_collector #(
        .BANDWIDTH (512),
        .BITWIDTH  (32),
        .PIPE_LAT  (PIPE_LAT),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_calc  (clk_calc),
        .areset    (areset),
        .acc_data  (acc_data),
        .last_in   (last_in),
        .flush     (flush),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .pack_stall(pack_stall),
        .ovf_err   (ovf_err)
    );

    initial clk_calc = 1'b0;
    always #5 clk_calc = ~clk_calc;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge. acc_data is garbage except on scheduled cap cycles.
    task automatic step();
        @(posedge clk_calc);
        cyc++;
        #1;
        last_in  = 1'b0;
        flush    = 1'b0;
        acc_data = acc_sched.exists(cyc) ? acc_sched[cyc] : 32'hDEADBEEF;
    endtask

    task automatic issue(input logic [31:0] v);
        last_in = 1'b1;
        acc_sched[cyc + PIPE_LAT] = v;
    endtask

    function automatic logic [511:0] word_of(input logic [31:0] base);
        logic [15:0][31:0] w;
        for (int k = 0; k < 16; k++) w[k] = base + 32'(k);
        return w;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int t0;
        int last_cap;
        t0 = cyc;
        for (int k = 0; k < int'(v.n); k++) begin
            issue(v.vals[k]);
            step();
        end
        last_cap = t0 + int'(v.n) - 1 + PIPE_LAT;
        while (cyc < last_cap) step();
        if (v.mode == 2'd1) begin
            flush = 1'b1;
        end else if (v.mode == 2'd2) begin
            step();
            flush = 1'b1;
        end
        check({tag, "_vld_early"}, out_vld, 1'b0);
        step();
        check({tag, "_vld"}, out_vld, 1'b1);
        check({tag, "_data"}, out_data, v.exp_lanes);
        check({tag, "_mask"}, out_mask, v.exp_mask);
        step();
        check({tag, "_vld_popped"}, out_vld, 1'b0);
        flush = 1'b1;
        step();
        step();
        check({tag, "_reflush_empty"}, out_vld, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        vec_t v;

        for (int i = 0; i < 5; i++) vecs[i] = '0;
        for (int k = 0; k < 16; k++) begin
            vecs[0].vals[k] = 32'h3F800000 + 32'(k);
            vecs[2].vals[k] = 32'h42000000 + 32'(k);
        end
        vecs[0].exp_lanes = vecs[0].vals;
        vecs[0].n = 5'd16; vecs[0].mode = 2'd0; vecs[0].exp_mask = 16'hFFFF;
        vecs[2].exp_lanes = vecs[2].vals;
        vecs[2].n = 5'd16; vecs[2].mode = 2'd1; vecs[2].exp_mask = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            vecs[1].vals[k]      = 32'h40000000 + 32'(k);
            vecs[1].exp_lanes[k] = 32'h40000000 + 32'(k);
        end
        vecs[1].n = 5'd5; vecs[1].mode = 2'd2; vecs[1].exp_mask = 16'h001F;
        vecs[3].vals[0] = 32'hBF800000;
        vecs[3].vals[1] = 32'h80000000;
        vecs[3].vals[2] = 32'hFFC00000;
        vecs[3].vals[3] = 32'h40000000;
`ifdef RESULT_RELU_EN
        vecs[3].exp_lanes[0] = 32'h00000000;
        vecs[3].exp_lanes[1] = 32'h00000000;
`else
        vecs[3].exp_lanes[0] = 32'hBF800000;
        vecs[3].exp_lanes[1] = 32'h80000000;
`endif
        vecs[3].exp_lanes[2] = 32'hFFC00000;
        vecs[3].exp_lanes[3] = 32'h40000000;
        vecs[3].n = 5'd4; vecs[3].mode = 2'd2; vecs[3].exp_mask = 16'h000F;
        vecs[4].vals[0] = 32'h3F000000;
        vecs[4].exp_lanes[0] = 32'h3F000000;
        vecs[4].n = 5'd1; vecs[4].mode = 2'd1; vecs[4].exp_mask = 16'h0001;

        areset   = 1'b1;
        last_in  = 1'b0;
        flush    = 1'b0;
        out_rdy  = 1'b1;
        acc_data = 32'hDEADBEEF;
        step();
        step();
        areset = 1'b0;
        step();
        check("rst_out_data", out_data, '0);
        check("rst_out_mask", out_mask, '0);
        check("rst_out_vld", out_vld, 1'b0);
        check("rst_pack_stall", pack_stall, 1'b0);
        check("rst_ovf_err", ovf_err, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset with 2 words queued, 7 lanes packed and 3 strobes still in the delay line.
        out_rdy = 1'b0;
        t0 = cyc;
        for (int c = 0; c < 39; c++) begin
            issue(32'h45000000 + 32'(c));
            step();
        end
        while (cyc < t0 + 38 + PIPE_LAT + 1) step();
        check("prerst_vld", out_vld, 1'b1);
        check("prerst_data", out_data, word_of(32'h45000000));
        for (int c = 0; c < 3; c++) begin
            last_in = 1'b1;
            step();
        end
        areset = 1'b1;
        step();
        check("midrst_out_data", out_data, '0);
        check("midrst_out_mask", out_mask, '0);
        check("midrst_out_vld", out_vld, 1'b0);
        check("midrst_pack_stall", pack_stall, 1'b0);
        areset = 1'b0;
        for (int c = 0; c < 25; c++) step();
        check("postrst_idle_vld", out_vld, 1'b0);
        out_rdy = 1'b1;
        v = '0;
        v.vals = word_of(32'h46000000);
        v.exp_lanes = v.vals;
        v.n = 5'd16; v.mode = 2'd0; v.exp_mask = 16'hFFFF;
        run_vec(v, "postrst");

        // Fifth word completes on a full FIFO in the same cycle the head is popped.
        out_rdy = 1'b0;
        t0 = cyc;
        for (int c = 0; c < 105; c++) begin
            if (c < 80) issue(32'h44000000 + 32'(c));
            if (c == PIPE_LAT + 16*3 + 15 + 1) check("pp_stall_full", pack_stall, 1'b1);
            if (c == PIPE_LAT + 16*4 + 15) out_rdy = 1'b1;
            if (c == PIPE_LAT + 16*4 + 15 + 1) begin
                out_rdy = 1'b0;
                check("pp_ovf_clear", ovf_err, 1'b0);
                check("pp_head_w1", out_data, word_of(32'h44000010));
            end
            step();
        end
        out_rdy = 1'b1;
        for (int w = 1; w < 5; w++) begin
            check($sformatf("pp_drain_vld%0d", w), out_vld, 1'b1);
            check($sformatf("pp_drain_data%0d", w), out_data, word_of(32'h44000000 + 32'(16*w)));
            step();
        end
        check("pp_drained", out_vld, 1'b0);
        check("pp_ovf_final", ovf_err, 1'b0);

        // Overflow: five words against a stalled consumer.
        out_rdy = 1'b0;
        t0 = cyc;
        for (int c = 0; c < 120; c++) begin
            if (c < 80) issue(32'h41000000 + 32'(c));
            if (c == PIPE_LAT + 16*1 + 15 + 1) check("ovf_stall_after_w2", pack_stall, 1'b0);
            if (c == PIPE_LAT + 16*2 + 15 + 1) check("ovf_stall_after_w3", pack_stall, 1'b1);
            if (c == PIPE_LAT + 16*3 + 15 + 1) check("ovf_err_after_w4", ovf_err, 1'b0);
            if (c == PIPE_LAT + 16*4 + 15 + 1) check("ovf_err_after_w5", ovf_err, 1'b1);
            step();
        end
        check("ovf_head_held", out_data, word_of(32'h41000000));
        check("ovf_mask_held", out_mask, 16'hFFFF);
        out_rdy = 1'b1;
        for (int w = 0; w < 4; w++) begin
            check($sformatf("ovf_drain_vld%0d", w), out_vld, 1'b1);
            check($sformatf("ovf_drain_data%0d", w), out_data, word_of(32'h41000000 + 32'(16*w)));
            step();
        end
        check("ovf_drained", out_vld, 1'b0);
        check("ovf_sticky", ovf_err, 1'b1);
        check("ovf_stall_low", pack_stall, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
